poly_sub_mod_q: RTL and testbench

//   Final reduction stage directly downstream of poly_multi_v5. Consumes the
//   o_sum_one / o_sum_mone vectors and an addend polynomial e. Produces the
//   LAC product-plus-error polynomial c[i] = (sum_one[i] - sum_mone[i] + e[i]) mod Q.

---
 rtl/poly_sub_mod_q_if.sv | 24 ++
 rtl/poly_sub_mod_q.sv | 110 +++++++++++
 tb/tb_poly_sub_mod_q.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/poly_sub_mod_q_if.sv
// Bus bundle for poly_sub_mod_q: start pulse, the three input polynomials,
// and the registered result/status outputs.
interface poly_sub_mod_q_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 512
);
    logic               i_start;
    logic [WIDTH*N-1:0] i_sum_one;
    logic [WIDTH*N-1:0] i_sum_mone;
    logic [WIDTH*N-1:0] i_poly_e;
    logic [WIDTH*N-1:0] o_poly_c;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start, i_sum_one, i_sum_mone, i_poly_e,
        input  o_poly_c, o_busy, o_done
    );

    modport slave (
        input  i_start, i_sum_one, i_sum_mone, i_poly_e,
        output o_poly_c, o_busy, o_done
    );
endinterface

// File: rtl/poly_sub_mod_q.sv
// Final reduction stage: c[i] = (sum_one[i] - sum_mone[i] + e[i]) mod Q,
// LANES coefficients per cycle through a 2-stage pipeline, result held until restart.
module poly_sub_mod_q #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 512,
    parameter int unsigned Q     = 251,
    parameter int unsigned LANES = 8
) (
    input logic             i_clock,
    input logic             i_reset,
    poly_sub_mod_q_if.slave bus
);
    localparam int unsigned SLICES = N / LANES;
    localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned DW     = WIDTH + 2;
    localparam int unsigned IW     = $clog2(WIDTH * N);
    localparam logic [CW-1:0]        LAST  = CW'(SLICES - 1);
    localparam logic signed [DW-1:0] Q_S   = $signed(DW'(Q));

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       slice_cnt;
    logic [CW-1:0]       s1_slice;
    logic                s1_valid;
    logic signed [DW-1:0] s1_d [LANES];
    logic [WIDTH*N-1:0]  poly_c;
    logic                busy;
    logic                done;

    logic signed [DW-1:0] d_c    [LANES];
    logic [WIDTH-1:0]     r_c    [LANES];
    logic [IW-1:0]        ridx_c [LANES];
    logic [IW-1:0]        widx_c [LANES];

    assign bus.o_poly_c = poly_c;
    assign bus.o_busy   = busy;
    assign bus.o_done   = done;

    // Stage 1 datum for the slice being issued; range -(Q-1) .. 2Q-2 fits DW signed bits.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            ridx_c[l] = IW'((int'(slice_cnt) * int'(LANES) + l) * int'(WIDTH));
            d_c[l]    = $signed({2'b00, bus.i_sum_one[ridx_c[l] +: WIDTH]})
                      - $signed({2'b00, bus.i_sum_mone[ridx_c[l] +: WIDTH]})
                      + $signed({2'b00, bus.i_poly_e[ridx_c[l] +: WIDTH]});
        end
    end

    // Stage 2: a single conditional add/subtract of Q lands every datum in 0..Q-1.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            widx_c[l] = IW'((int'(s1_slice) * int'(LANES) + l) * int'(WIDTH));
            r_c[l]    = WIDTH'(s1_d[l]);
            if (s1_d[l] < 0) begin
                r_c[l] = WIDTH'(s1_d[l] + Q_S);
            end else if (s1_d[l] >= Q_S) begin
                r_c[l] = WIDTH'(s1_d[l] - Q_S);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= IDLE;
            slice_cnt <= '0;
            s1_slice  <= '0;
            s1_valid  <= 1'b0;
            s1_d      <= '{default: '0};
            poly_c    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (s1_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    poly_c[widx_c[l] +: WIDTH] <= r_c[l];
                end
            end
            s1_valid <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        state     <= RUN;
                        slice_cnt <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    s1_valid  <= 1'b1;
                    s1_slice  <= slice_cnt;
                    s1_d      <= d_c;
                    slice_cnt <= slice_cnt + 1'b1;
                    if (slice_cnt == LAST) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_poly_sub_mod_q.sv
// Directed/randomized bench for poly_sub_mod_q with an arithmetic mod-Q reference.
module tb_poly_sub_mod_q;
    localparam int W = 8;
    localparam int N = 512;
    localparam int Q = 251;
    localparam int EXP_LAT = 65;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    int one_a  [N];
    int mone_a [N];
    int e_a    [N];
    logic [W*N-1:0] exp_poly;
    logic [W*N-1:0] old_poly;
    logic [W*N-1:0] const_poly;

    poly_sub_mod_q_if #(.WIDTH(W), .N(N)) bus ();

    poly_sub_mod_q #(.WIDTH(W), .N(N), .Q(Q), .LANES(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_poly(string tag, logic [W*N-1:0] exp);
        int bad;
        bad = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.o_poly_c[i*W +: W] !== exp[i*W +: W]) bad = i;
        end
        vectors++;
        assert (bus.o_poly_c === exp) else begin
            miscompares++;
            $error("FAIL %s coeff %0d observed %0d expected %0d", tag, bad,
                   bus.o_poly_c[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    // Reference: plain integer arithmetic, reduced into 0..Q-1.
    function automatic logic [W*N-1:0] model();
        logic [W*N-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            v = ((one_a[i] - mone_a[i] + e_a[i]) % Q + Q) % Q;
            r[i*W +: W] = W'(v);
        end
        return r;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            bus.i_sum_one[i*W +: W]  = W'(one_a[i]);
            bus.i_sum_mone[i*W +: W] = W'(mone_a[i]);
            bus.i_poly_e[i*W +: W]   = W'(e_a[i]);
        end
    endtask

    task automatic fill(int o, int m, int e);
        for (int i = 0; i < N; i++) begin
            one_a[i] = o; mone_a[i] = m; e_a[i] = e;
        end
        drive_inputs();
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            one_a[i]  = int'($urandom_range(0, Q - 1));
            mone_a[i] = int'($urandom_range(0, Q - 1));
            e_a[i]    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, Q - 1));
        end
        drive_inputs();
    endtask

    // Pulse start for one edge; checks done falls / busy rises on that edge.
    task automatic pulse_start(string tag);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk({tag, "_done_fall"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_busy_rise"}, 32'(bus.o_busy), 32'd1);
    endtask

    // Waits (bounded) for done; lat counts edges after the start edge.
    task automatic wait_done(string tag, int already, int repulse_at);
        int lat;
        int busy_n;
        lat = already;
        busy_n = already;
        while (!bus.o_done && lat < 300) begin
            if (bus.o_busy) busy_n++;
            bus.i_start = (lat == repulse_at) ? 1'b1 : 1'b0;
            tick();
            lat++;
        end
        bus.i_start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(EXP_LAT));
        chk({tag, "_busy_low"}, 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.i_start = 1'b0;
        fill(0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_poly("reset_poly", '0);
        chk("reset_busy", 32'(bus.o_busy), 32'd0);
        chk("reset_done", 32'(bus.o_done), 32'd0);

        // All-zero inputs
        fill(0, 0, 0);
        pulse_start("zero");
        wait_done("zero", 0, -1);
        chk_poly("zero_poly", '0);

        // Negative wrap: 0 - 1 + 0 -> Q-1
        fill(0, 1, 0);
        const_poly = {N{8'd250}};
        pulse_start("negwrap");
        wait_done("negwrap", 0, -1);
        chk_poly("negwrap_poly", const_poly);

        // Upper wrap at the maximum datum 2Q-2
        fill(250, 0, 250);
        const_poly = {N{8'd249}};
        pulse_start("upwrap");
        wait_done("upwrap", 0, -1);
        chk_poly("upwrap_poly", const_poly);

        // Random vectors against the reference
        for (int v = 0; v < 20; v++) begin
            fill_random();
            exp_poly = model();
            pulse_start("rand");
            wait_done("rand", 0, -1);
            chk_poly("rand_poly", exp_poly);
        end

        // Restart from DONE: start held until done falls; old contents survive
        // in slices not yet rewritten.
        old_poly = exp_poly;
        fill_random();
        exp_poly = model();
        bus.i_start = 1'b1;
        tick();
        chk("restart_done_fall", 32'(bus.o_done), 32'd0);
        bus.i_start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("restart_old_top", 32'(bus.o_poly_c[(N-1)*W +: W]), 32'(old_poly[(N-1)*W +: W]));
        wait_done("restart", 5, -1);
        chk_poly("restart_poly", exp_poly);

        // Start re-pulsed mid-run is ignored
        fill_random();
        exp_poly = model();
        pulse_start("repulse");
        wait_done("repulse", 0, 10);
        chk_poly("repulse_poly", exp_poly);

        // Reset mid-run clears everything and returns to IDLE
        fill_random();
        pulse_start("midreset");
        for (int c = 0; c < 30; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_poly("midreset_poly", '0);
        chk("midreset_done", 32'(bus.o_done), 32'd0);
        chk("midreset_busy", 32'(bus.o_busy), 32'd0);
        tick();
        tick();
        chk("midreset_idle", 32'(bus.o_busy), 32'd0);

        // Fresh run from IDLE after reset
        exp_poly = model();
        pulse_start("postreset");
        wait_done("postreset", 0, -1);
        chk_poly("postreset_poly", exp_poly);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
